// File: rtl/tnn_layer_sched.sv
// Sequences a sample of operand groups through one shared combinational neuron core,
// one enabled neuron per cycle, and collects the decisions into a result vector.
module tnn_layer_sched #(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned OPW       = 3,
  localparam int unsigned SEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int unsigned CNT_W    = $clog2(N_NEURONS + 1),
  localparam int unsigned GRP_W    = 5 * OPW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_NEURONS*GRP_W-1:0]   in_data,
  input  logic [N_NEURONS-1:0]         in_mask,
  output logic [OPW-1:0]               core_a,
  output logic [OPW-1:0]               core_b,
  output logic [OPW-1:0]               core_c,
  output logic [OPW-1:0]               core_d,
  output logic [OPW-1:0]               core_e,
  input  logic                         core_out,
  output logic [SEL_W-1:0]             core_sel,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_NEURONS-1:0]         out_bits,
  output logic [CNT_W-1:0]             out_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [SEL_W-1:0]             idx_q, idx_d;
  logic [N_NEURONS*GRP_W-1:0]   data_q;
  logic [N_NEURONS-1:0]         mask_q;
  logic [N_NEURONS-1:0]         bits_q, bits_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         accept;
  logic [SEL_W:0]               first_set;
  logic [SEL_W:0]               next_set;
  logic [GRP_W-1:0]             grp;
  logic                         run;

  // Lowest set bit of m at or above index lo; MSB of the result flags "found".
  function automatic logic [SEL_W:0] find_set(input logic [N_NEURONS-1:0] m, input int lo);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = int'(N_NEURONS) - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  assign first_set = find_set(in_mask, 0);
  assign next_set  = find_set(mask_q, int'(idx_q) + 1);

  // Operand group currently selected by idx.
  always_comb begin
    grp = '0;
    for (int k = 0; k < int'(N_NEURONS); k++) begin
      if (idx_q == SEL_W'(k)) grp = data_q[k*GRP_W +: GRP_W];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          bits_d  = '0;
          cnt_d   = '0;
          idx_d   = first_set[SEL_W-1:0];
          state_d = first_set[SEL_W] ? RUN : DONE;
        end
      end
      RUN: begin
        for (int k = 0; k < int'(N_NEURONS); k++) begin
          if (idx_q == SEL_W'(k)) bits_d[k] = core_out;
        end
        cnt_d = cnt_q + CNT_W'(core_out);
        if (next_set[SEL_W]) begin
          idx_d = next_set[SEL_W-1:0];
        end else begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      bits_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      idx_q  <= idx_d;
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
      if (accept) begin
        data_q <= in_data;
        mask_q <= in_mask;
      end
    end
  end

  assign run       = (state_q == RUN);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_bits  = bits_q;
  assign out_count = cnt_q;

  // Core operands are only live while evaluating; parked at zero otherwise.
  assign core_a   = run ? grp[0*OPW +: OPW] : '0;
  assign core_b   = run ? grp[1*OPW +: OPW] : '0;
  assign core_c   = run ? grp[2*OPW +: OPW] : '0;
  assign core_d   = run ? grp[3*OPW +: OPW] : '0;
  assign core_e   = run ? grp[4*OPW +: OPW] : '0;
  assign core_sel = run ? idx_q : '0;

endmodule

// File: tb/tb_tnn_layer_sched.sv
// Directed bench for tnn_layer_sched: transaction-level model plus per-cycle compare,
// with hand-computed literal checks on the key scenarios.
module tb_tnn_layer_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned OPW = 3;
  localparam int unsigned GW  = 5 * OPW;
  localparam int unsigned DW  = N * GW;
  localparam int unsigned SW  = 2;
  localparam int unsigned CW  = 3;
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic [N-1:0]   in_mask = '0;
  logic           in_ready, core_out, busy, out_valid;
  logic [OPW-1:0] core_a, core_b, core_c, core_d, core_e;
  logic [SW-1:0]  core_sel;
  logic [N-1:0]   out_bits;
  logic [CW-1:0]  out_count;
  logic [N-1:0]   resp = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in neuron core: a per-neuron decision table.
  assign core_out = resp[core_sel];

  tnn_layer_sched #(.N_NEURONS(N), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d), .core_e(core_e),
    .core_out(core_out), .core_sel(core_sel), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_count(out_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OPW-1:0] opnd(input logic [DW-1:0] d, input int k, input int j);
    return d[k*GW + j*OPW +: OPW];
  endfunction

  // Transaction model: which neurons get evaluated in which order, and the final vector.
  int             phase = P_IDLE;
  int             pos = 0;
  int             sel_q[$];
  logic [DW-1:0]  m_data = '0;
  logic [N-1:0]   m_bits = '0;
  int             m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = P_IDLE;
      pos   = 0;
    end else begin
      case (phase)
        P_IDLE: if (in_valid) begin
          m_data = in_data;
          m_bits = in_mask & resp;
          m_cnt  = $countones(in_mask & resp);
          sel_q.delete();
          for (int k = 0; k < int'(N); k++) if (in_mask[k]) sel_q.push_back(k);
          pos   = 0;
          phase = (sel_q.size() > 0) ? P_RUN : P_DONE;
        end
        P_RUN: begin
          pos++;
          if (pos >= sel_q.size()) phase = P_DONE;
        end
        P_DONE: if (out_ready) phase = P_IDLE;
        default: phase = P_IDLE;
      endcase
    end
  end

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready",  64'(in_ready), 64'(1));
      chk("rst_busy",      64'(busy), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_bits",  64'(out_bits), 64'(0));
      chk("rst_out_count", 64'(out_count), 64'(0));
      chk("rst_core",      64'({core_a, core_b, core_c, core_d, core_e, core_sel}), 64'(0));
    end else begin
      chk("in_ready",  64'(in_ready),  64'(phase == P_IDLE));
      chk("out_valid", 64'(out_valid), 64'(phase == P_DONE));
      chk("busy",      64'(busy),      64'(phase != P_IDLE));
      if (phase == P_RUN) begin : run_chk
        int k;
        k = sel_q[pos];
        chk("core_sel", 64'(core_sel), 64'(k));
        chk("core_a", 64'(core_a), 64'(opnd(m_data, k, 0)));
        chk("core_b", 64'(core_b), 64'(opnd(m_data, k, 1)));
        chk("core_c", 64'(core_c), 64'(opnd(m_data, k, 2)));
        chk("core_d", 64'(core_d), 64'(opnd(m_data, k, 3)));
        chk("core_e", 64'(core_e), 64'(opnd(m_data, k, 4)));
      end else begin
        chk("core_idle", 64'({core_a, core_b, core_c, core_d, core_e, core_sel}), 64'(0));
      end
      if (phase == P_DONE) begin
        chk("out_bits",  64'(out_bits),  64'(m_bits));
        chk("out_count", 64'(out_count), 64'(m_cnt));
      end
    end
  end

  function automatic logic [DW-1:0] route_data();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < int'(N); k++) begin
      d[k*GW + 0*OPW +: OPW] = OPW'(k);
      d[k*GW + 1*OPW +: OPW] = OPW'(k + 1);
      d[k*GW + 2*OPW +: OPW] = OPW'(2);
      d[k*GW + 3*OPW +: OPW] = OPW'(3);
      d[k*GW + 4*OPW +: OPW] = OPW'(4);
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Offer a sample while idle; returns #1 after the accepting edge with inputs scrambled.
  task automatic send(input logic [DW-1:0] d, input logic [N-1:0] m);
    in_data  = d;
    in_mask  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("accepted", 64'(busy), 64'(1));
    in_valid = 1'b0;
    in_data  = ~d;
    in_mask  = ~m;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_timeout", 64'(out_valid), 64'(1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_in_ready",  64'(in_ready), 64'(1));
    chk("drain_out_valid", 64'(out_valid), 64'(0));
  endtask

  logic [N-1:0] lp_mask [4] = '{4'b0001, 4'b1000, 4'b0111, 4'b1110};
  logic [N-1:0] lp_resp [4] = '{4'b1111, 4'b1000, 4'b0101, 4'b0110};

  initial begin
    int lat;
    int n;

    // Full mask with operand routing; sample already offered during reset.
    resp     = 4'b1101;
    in_data  = route_data();
    in_mask  = 4'b1111;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("accept_after_reset", 64'(busy), 64'(1));
    in_valid = 1'b0;
    in_data  = '1;
    in_mask  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      chk("full_sel", 64'(core_sel), 64'(k));
      chk("route_a", 64'(core_a), 64'(k));
      chk("route_b", 64'(core_b), 64'(k + 1));
      chk("route_cde", 64'({core_c, core_d, core_e}), 64'({3'd2, 3'd3, 3'd4}));
      @(posedge clk); #1;
    end
    chk("full_latency5", 64'(out_valid), 64'(1));
    chk("full_bits", 64'(out_bits), 64'(4'b1101));
    chk("full_count", 64'(out_count), 64'(3));
    drain();

    // Sparse mask: only neurons 1 and 3 evaluated.
    resp = 4'b1111;
    send(rnd_data(), 4'b1010);
    chk("sparse_sel1", 64'(core_sel), 64'(1));
    @(posedge clk); #1;
    chk("sparse_sel3", 64'(core_sel), 64'(3));
    @(posedge clk); #1;
    chk("sparse_latency3", 64'(out_valid), 64'(1));
    chk("sparse_bits", 64'(out_bits), 64'(4'b1010));
    chk("sparse_count", 64'(out_count), 64'(2));
    drain();

    // Zero mask: straight to the result.
    send(rnd_data(), 4'b0000);
    chk("zero_latency1", 64'(out_valid), 64'(1));
    chk("zero_bits", 64'(out_bits), 64'(0));
    chk("zero_count", 64'(out_count), 64'(0));
    chk("zero_core", 64'({core_a, core_b, core_c, core_d, core_e}), 64'(0));
    drain();

    // Backpressure with the next sample waiting on in_valid throughout.
    resp = 4'b0011;
    send(rnd_data(), 4'b0110);
    in_valid = 1'b1;
    in_data  = rnd_data();
    in_mask  = 4'b1001;
    wait_done(lat);
    chk("bp_latency", 64'(lat), 64'(3));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_bits_stable", 64'(out_bits), 64'(4'b0010));
      chk("bp_count_stable", 64'(out_count), 64'(1));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_xfer_idle", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    chk("bp_next_accept", 64'(busy), 64'(1));
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp2_latency", 64'(lat), 64'(3));
    chk("bp2_bits", 64'(out_bits), 64'(4'b0001));
    chk("bp2_count", 64'(out_count), 64'(1));
    drain();

    // Reset while evaluating neuron 2.
    resp = 4'b1111;
    send(rnd_data(), 4'b1111);
    n = 0;
    while (core_sel != 2'd2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_reach_sel2", 64'(core_sel), 64'(2));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_bits", 64'(out_bits), 64'(0));
    chk("midrst_count", 64'(out_count), 64'(0));
    chk("midrst_core", 64'({core_a, core_b, core_c, core_d, core_e, core_sel}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 64'(out_valid), 64'(0));
    end
    resp = 4'b0110;
    send(rnd_data(), 4'b0101);
    wait_done(lat);
    chk("postrst_latency", 64'(lat), 64'(3));
    chk("postrst_bits", 64'(out_bits), 64'(4'b0100));
    chk("postrst_count", 64'(out_count), 64'(1));
    drain();

    // Assorted masks, checked by the per-cycle compare and latency rule.
    for (int t = 0; t < 4; t++) begin
      resp = lp_resp[t];
      send(rnd_data(), lp_mask[t]);
      wait_done(lat);
      chk("loop_latency", 64'(lat), 64'($countones(lp_mask[t]) + 1));
      drain();
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
